// File: rtl/i2s_audio_tx.sv
// Philips-format I2S serialiser with an integer BCK divider and double-buffered stereo samples.
// Optional build macro I2S_UNSIGNED_IN_EN: inputs are offset-binary and get their MSB inverted on capture.
module i2s_audio_tx #(
    parameter int AUDIO_DW  = 16,
    parameter int SLOT_BITS = 32,
    parameter int BCK_DIV   = 8
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [AUDIO_DW-1:0] left_in,
    input  logic [AUDIO_DW-1:0] right_in,
    input  logic                sample_we,
    output logic                sample_req,
    output logic                i2s_bck,
    output logic                i2s_lrck,
    output logic                i2s_data
);

    localparam int DIV_W  = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam int SLOT_W = $clog2(SLOT_BITS);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_BITS - 1);

    logic [DIV_W-1:0]           div_cnt;
    logic [SLOT_W-1:0]          slot;
    logic signed [AUDIO_DW-1:0] hold_l;
    logic signed [AUDIO_DW-1:0] hold_r;
    logic signed [AUDIO_DW-1:0] shadow_l;
    logic signed [AUDIO_DW-1:0] shadow_r;

    logic                       fall;
    logic                       load;
    logic [SLOT_W-1:0]          slot_nxt;
    logic                       lrck_nxt;
    logic signed [AUDIO_DW-1:0] shadow_l_nxt;
    logic signed [AUDIO_DW-1:0] shadow_r_nxt;
    logic signed [AUDIO_DW-1:0] word;

    function automatic logic signed [AUDIO_DW-1:0] in_conv(input logic [AUDIO_DW-1:0] x);
`ifdef I2S_UNSIGNED_IN_EN
        in_conv = $signed({~x[AUDIO_DW-1], x[AUDIO_DW-2:0]});
`else
        in_conv = $signed(x);
`endif
    endfunction

    // Slot 0 is the one-bit I2S delay; slots 1..AUDIO_DW carry MSB first, the rest pad with zero.
    function automatic logic pick_bit(input logic [SLOT_W-1:0] s,
                                      input logic signed [AUDIO_DW-1:0] w);
        int k;
        k = int'(s);
        pick_bit = 1'b0;
        for (int i = 0; i < AUDIO_DW; i++) begin
            if (k == AUDIO_DW - i) pick_bit = w[i];
        end
    endfunction

    always_comb begin
        fall         = (div_cnt == DIV_LAST) && i2s_bck;
        slot_nxt     = (slot == SLOT_LAST) ? '0 : slot + 1'b1;
        lrck_nxt     = (slot_nxt == '0) ? ~i2s_lrck : i2s_lrck;
        load         = fall && i2s_lrck && !lrck_nxt;
        shadow_l_nxt = shadow_l;
        shadow_r_nxt = shadow_r;
        if (load) begin
            shadow_l_nxt = sample_we ? in_conv(left_in)  : hold_l;
            shadow_r_nxt = sample_we ? in_conv(right_in) : hold_r;
        end
        word = lrck_nxt ? shadow_r_nxt : shadow_l_nxt;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            slot       <= SLOT_LAST;
            i2s_bck    <= 1'b0;
            i2s_lrck   <= 1'b1;
            i2s_data   <= 1'b0;
            sample_req <= 1'b0;
            hold_l     <= '0;
            hold_r     <= '0;
            shadow_l   <= '0;
            shadow_r   <= '0;
        end else begin
            sample_req <= load;
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                i2s_bck <= ~i2s_bck;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (sample_we) begin
                hold_l <= in_conv(left_in);
                hold_r <= in_conv(right_in);
            end
            shadow_l <= shadow_l_nxt;
            shadow_r <= shadow_r_nxt;
            // Everything but BCK moves on the falling BCK edge so it is stable at the rising edge.
            if (fall) begin
                slot     <= slot_nxt;
                i2s_lrck <= lrck_nxt;
                i2s_data <= pick_bit(slot_nxt, word);
            end
        end
    end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Bench for i2s_audio_tx: frame-level model compared every cycle, plus decoded-word literal checks.
module tb_i2s_audio_tx;

    localparam int AUDIO_DW  = 16;
    localparam int SLOT_BITS = 32;
    localparam int BCK_DIV   = 2;
    localparam int HALF      = BCK_DIV;
    localparam int BCK_P     = 2 * BCK_DIV;
    localparam int FRAME     = 2 * SLOT_BITS * BCK_P;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] left_in = '0;
    logic [15:0] right_in = '0;
    logic        sample_we = 1'b0;
    logic        sample_req, i2s_bck, i2s_lrck, i2s_data;

    int checks = 0;
    int failures = 0;

    i2s_audio_tx #(.AUDIO_DW(AUDIO_DW), .SLOT_BITS(SLOT_BITS), .BCK_DIV(BCK_DIV)) dut (
        .clk_sys(clk), .reset(rst), .left_in(left_in), .right_in(right_in),
        .sample_we(sample_we), .sample_req(sample_req), .i2s_bck(i2s_bck),
        .i2s_lrck(i2s_lrck), .i2s_data(i2s_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] conv(input logic [15:0] x);
`ifdef I2S_UNSIGNED_IN_EN
        conv = x ^ 16'h8000;
`else
        conv = x;
`endif
    endfunction

    // Model: t counts clk edges since reset release; frame loads happen at t = BCK_P*(1 + 2*SLOT_BITS*m).
    int          t = 0;
    logic [15:0] m_hold_l = '0, m_hold_r = '0, m_sh_l = '0, m_sh_r = '0;

    function automatic logic is_load(input int tt);
        int n;
        n = tt / BCK_P;
        is_load = (tt > 0) && (tt % BCK_P == 0) && ((n - 1) % (2 * SLOT_BITS) == 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t = 0;
            m_hold_l = '0; m_hold_r = '0; m_sh_l = '0; m_sh_r = '0;
        end else begin
            if (is_load(t + 1)) begin
                m_sh_l = sample_we ? conv(left_in)  : m_hold_l;
                m_sh_r = sample_we ? conv(right_in) : m_hold_r;
            end
            if (sample_we) begin
                m_hold_l = conv(left_in);
                m_hold_r = conv(right_in);
            end
            t = t + 1;
        end
    end

    int req_count = 0;

    always @(negedge clk) begin
        int n, k;
        logic [15:0] w;
        logic [3:0]  exp_o;
        logic        eb, el, ed, er;
        n  = t / BCK_P;
        eb = ((t / HALF) % 2) == 1;
        el = 1'b1; ed = 1'b0; er = 1'b0;
        if (n > 0) begin
            k  = (n - 1) % SLOT_BITS;
            el = (((n - 1) / SLOT_BITS) % 2) == 1;
            er = is_load(t);
            w  = el ? m_sh_r : m_sh_l;
            if (k >= 1 && k <= AUDIO_DW) ed = w[4'(AUDIO_DW - k)];
        end
        exp_o = {eb, el, ed, er};
        checks++;
        if ({i2s_bck, i2s_lrck, i2s_data, sample_req} !== exp_o) begin
            failures++;
            $display("FAIL model_cycle t=%0d bck/lrck/data/req got=%b want=%b",
                     t, {i2s_bck, i2s_lrck, i2s_data, sample_req}, exp_o);
        end
        if (sample_req) req_count++;
    end

    // Decode words from the pins on BCK rising edges, independent of the model.
    logic        col_valid = 1'b0, col_prev = 1'b1, col_pad_ok = 1'b1;
    int          col_idx = 0;
    logic [15:0] col_word = '0, last_l = 16'hDEAD, last_r = 16'hDEAD;
    logic        pad_l = 1'b0, pad_r = 1'b0;

    always @(posedge i2s_bck or posedge rst) begin
        if (rst) begin
            col_valid = 1'b0;
            col_prev  = 1'b1;
        end else begin
            if (i2s_lrck != col_prev) begin
                col_valid = 1'b1; col_idx = 0; col_word = '0; col_pad_ok = 1'b1;
            end else begin
                col_idx++;
            end
            col_prev = i2s_lrck;
            if (col_valid) begin
                if (col_idx >= 1 && col_idx <= AUDIO_DW) col_word = {col_word[14:0], i2s_data};
                else if (i2s_data) col_pad_ok = 1'b0;
                if (col_idx == SLOT_BITS - 1) begin
                    if (i2s_lrck) begin last_r = col_word; pad_r = col_pad_ok; end
                    else begin last_l = col_word; pad_l = col_pad_ok; end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic at_t(input int target);
        int guard;
        guard = 0;
        while (t < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (t != target) begin
            failures++; checks++;
            $display("FAIL at_t reached t=%0d want=%0d", t, target);
        end
    endtask

    task automatic write(input logic [15:0] l, input logic [15:0] r);
        sample_we = 1'b1; left_in = l; right_in = r;
        @(negedge clk);
        sample_we = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: timing landmarks and silent words.
        at_t(3);   chk("pre_fall_lrck", 32'(i2s_lrck), 32'd1);
        at_t(4);   chk("first_fall_lrck_req", {30'd0, i2s_lrck, sample_req}, 32'b01);
        at_t(131); chk("left_slot_end_lrck", 32'(i2s_lrck), 32'd0);
        at_t(132); chk("lrck_rise", 32'(i2s_lrck), 32'd1);
        at_t(135); chk("idle_left_word", {15'd0, pad_l, last_l}, {15'd0, 1'b1, 16'h0000});
        at_t(260); chk("second_req", 32'(sample_req), 32'd1);

        // Ordinary write ahead of a frame load.
        at_t(300); write(16'h8001, 16'h7FFE);
        at_t(645); chk("left_8001", {15'd0, pad_l, last_l}, {15'd0, 1'b1, conv(16'h8001)});
        at_t(700); write(16'h1111, 16'h2222);
        at_t(771); chk("right_7FFE", {15'd0, pad_r, last_r}, {15'd0, 1'b1, conv(16'h7FFE)});

        // Write sampled on the frame-load edge bypasses hold.
        sample_we = 1'b1; left_in = 16'h1234; right_in = 16'h4321;
        at_t(772); sample_we = 1'b0;
        chk("bypass_req", 32'(sample_req), 32'd1);
        at_t(900);  chk("bypass_left", 32'(last_l), 32'(conv(16'h1234)));
        at_t(1027); chk("bypass_right", 32'(last_r), 32'(conv(16'h4321)));

        // Underrun: one write, then three frames repeat it.
        at_t(1030); write(16'hA5A5, 16'h5A5A);
        req_count = 0;
        at_t(1412); chk("underrun_left_1", 32'(last_l), 32'(conv(16'hA5A5)));
        at_t(1540); chk("underrun_right_1", 32'(last_r), 32'(conv(16'h5A5A)));
        at_t(1668); chk("underrun_left_2", 32'(last_l), 32'(conv(16'hA5A5)));
        at_t(1924); chk("underrun_left_3", 32'(last_l), 32'(conv(16'hA5A5)));
        at_t(1930); chk("req_count_3_frames", 32'(req_count), 32'd3);

        // Asynchronous reset in the middle of a right slot.
        at_t(1960);
        chk("mid_right_lrck", 32'(i2s_lrck), 32'd1);
        #1 rst = 1'b1;
        #1 chk("async_reset_outs", {28'd0, i2s_bck, i2s_lrck, i2s_data, sample_req}, 32'b0100);
        @(negedge clk);
        #1 rst = 1'b0;
        at_t(3);   chk("post_reset_pre_fall", 32'(i2s_lrck), 32'd1);
        at_t(4);   chk("post_reset_fall", {30'd0, i2s_lrck, sample_req}, 32'b01);
        at_t(135); chk("post_reset_left_zero", {15'd0, pad_l, last_l}, {15'd0, 1'b1, 16'h0000});

        // Offset-binary corner values.
        at_t(200); write(16'h8000, 16'hFFFF);
        at_t(259); chk("post_reset_right_zero", 32'(last_r), 32'h0);
`ifdef I2S_UNSIGNED_IN_EN
        at_t(390); chk("corner_left", 32'(last_l), 32'h0000);
        at_t(518); chk("corner_right", 32'(last_r), 32'h7FFF);
`else
        at_t(390); chk("corner_left", 32'(last_l), 32'h8000);
        at_t(518); chk("corner_right", 32'(last_r), 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
